// File: rtl/triangular_pwm_pkg.sv
// Shared constants and types for the center-aligned PWM generator.
// Optional build macro used by the top: TRIANGULAR_PWM_SYNC_EN.
package triangular_pwm_pkg;

  localparam int DEFAULT_DUTY_WIDTH = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/triangular_pwm_tri_carrier.sv
// Triangular carrier: counts 0 -> MAX -> 0, holding each endpoint for two cycles,
// and flags the valley cycle where the next period's duty is latched.
module triangular_pwm_tri_carrier
  import triangular_pwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DUTY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cnt,
  output logic             period_boundary
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  dir_e             dir;
  dir_e             dir_nxt;
  logic [WIDTH-1:0] cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    unique case (dir)
      DIR_UP: begin
        if (cnt == CNT_MAX) dir_nxt = DIR_DOWN;
        else                cnt_nxt = cnt + 1'b1;
      end
      DIR_DOWN: begin
        if (cnt == '0) dir_nxt = DIR_UP;
        else           cnt_nxt = cnt - 1'b1;
      end
      default: begin
        cnt_nxt = cnt;
        dir_nxt = DIR_UP;
      end
    endcase
  end

  always_comb begin
    period_boundary = (dir == DIR_DOWN) && (cnt == '0);
  end

endmodule

// File: rtl/triangular_pwm.sv
// Center-aligned PWM: duty latched once per period at the carrier valley,
// registered compare output. Define TRIANGULAR_PWM_SYNC_EN to add period_sync.
module triangular_pwm
  import triangular_pwm_pkg::*;
#(
  parameter int DUTY_WIDTH = DEFAULT_DUTY_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DUTY_WIDTH-1:0] duty,
  output logic                  pwm_out
`ifdef TRIANGULAR_PWM_SYNC_EN
  ,
  output logic                  period_sync
`endif
);

  logic [DUTY_WIDTH-1:0] cnt;
  logic [DUTY_WIDTH-1:0] duty_q;
  logic                  period_boundary;

  triangular_pwm_tri_carrier #(
    .WIDTH(DUTY_WIDTH)
  ) u_tri_carrier (
    .clk             (clk),
    .rst             (rst),
    .cnt             (cnt),
    .period_boundary (period_boundary)
  );

  // Duty only changes at the valley so a period never sees a mid-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (period_boundary) duty_q <= duty;
      pwm_out <= (cnt < duty_q);
    end
  end

`ifdef TRIANGULAR_PWM_SYNC_EN
  // Delayed by one cycle to line up with the registered pwm_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_sync <= 1'b0;
    else     period_sync <= period_boundary;
  end
`endif

endmodule

// File: tb/tb_triangular_pwm.sv
// Scoreboard bench for triangular_pwm: stimulus queues the expected high count of
// each 512-cycle period, a monitor measures every output window and compares.
module tb_triangular_pwm;
  import triangular_pwm_pkg::*;

  localparam int N      = 8;
  localparam int PERIOD = 512;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] duty;
  logic         pwm_out;
`ifdef TRIANGULAR_PWM_SYNC_EN
  logic         period_sync;
`endif

  triangular_pwm #(
    .DUTY_WIDTH(N)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .duty        (duty),
    .pwm_out     (pwm_out)
`ifdef TRIANGULAR_PWM_SYNC_EN
    ,
    .period_sync (period_sync)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: window for period p covers output cycles 512p+1 .. 512p+512 after
  // reset release. With duty d the output is high for the first d and last d
  // cycles of the window, so consecutive equal periods form one run over the valley.
  int k         = 0;
  int win_i     = 0;
  int cur_exp   = 0;
  int half      = 0;
  bit cur_valid = 1'b0;
  int high_cnt  = 0;
  int shape_dev = 0;
  int sync_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        k         = 0;
        cur_valid = 1'b0;
        exp_q.delete();
      end else if (!clk) begin
        k++;
        win_i = ((k - 1) % PERIOD) + 1;
        if (win_i == 1) begin
          cur_valid = (exp_q.size() > 0);
          if (cur_valid) cur_exp = exp_q.pop_front();
          high_cnt  = 0;
          shape_dev = 0;
          sync_cnt  = 0;
        end
        if (cur_valid) begin
          half = cur_exp / 2;
          if (pwm_out === 1'b1) high_cnt++;
          if (pwm_out !== ((win_i <= half) || (win_i > PERIOD - half))) shape_dev++;
`ifdef TRIANGULAR_PWM_SYNC_EN
          if (period_sync === 1'b1) begin
            sync_cnt++;
            if (win_i != PERIOD) shape_dev++;
          end
`endif
          if (win_i == PERIOD) begin
            check("period_high_count", high_cnt, cur_exp);
            check("period_shape_deviations", shape_dev, 0);
`ifdef TRIANGULAR_PWM_SYNC_EN
            check("period_sync_pulses", sync_cnt, 1);
`endif
          end
        end
      end
    end
  end

  // Apply duty at carrier offset 100 (counting up); it governs the next n periods.
  task automatic run_entry(input int d, input int n, input int exp_high);
    duty = N'(d);
    repeat (n) exp_q.push_back(exp_high);
    repeat (PERIOD * n) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    duty = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_cnt", int'(u_dut.u_tri_carrier.cnt), 0);
    check("reset_dir", int'(u_dut.u_tri_carrier.dir), int'(DIR_UP));
    #2 rst = 1'b0;
    exp_q.push_back(0);
    repeat (100) @(negedge clk);

    run_entry(0,   6, 0);
    run_entry(8,   6, 16);
    run_entry(16,  6, 32);
    run_entry(32,  6, 64);
    run_entry(128, 6, 256);
    run_entry(192, 6, 384);
    run_entry(255, 3, 510);

    // Mid-period asynchronous reset while the output is high.
    check("pre_reset_pwm_high", int'(pwm_out), 1);
    #2 rst = 1'b1;
    #1 check("async_reset_pwm_drop", int'(pwm_out), 0);
    check("async_reset_cnt", int'(u_dut.u_tri_carrier.cnt), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset2_pwm_out", int'(pwm_out), 0);
    #2 rst = 1'b0;
    exp_q.push_back(0);
    repeat (100) @(negedge clk);

    run_entry(64,  3, 128);
    run_entry(192, 3, 384);
    repeat (420) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/triangular_pwm.md
Name: triangular_pwm

Overview:
Center-aligned (triangular-carrier) PWM generator.
- An N-bit up/down counter sweeps 0 -> 2^N-1 -> 0.
- The output is high while the carrier is below a duty threshold, giving a symmetric pulse centered on the carrier valley.
- Used as a leaf block driving motor/LED drivers. The duty input comes from software-visible registers.

Parameters:
- DUTY_WIDTH, default 8: width N of duty and carrier counter. Carrier maximum is MAX = 2^N-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- duty  input  DUTY_WIDTH  requested on-time. High cycles per period = 2*duty.
- pwm_out  output  1  registered PWM output.

Behaviour:
- One clock; reset is asynchronous and active-high (port rst); all state is clocked on rising clk.
- State:
  - cnt[N-1:0], the carrier.
  - dir_up, 1 = counting up.
  - duty_q[N-1:0], the latched duty.
  - pwm_out register.
- Reset values: cnt=0, dir_up=1, duty_q=0, pwm_out=0. Reset asserted mid-period aborts the period immediately.
- Carrier sequence: 0,1,...,MAX,MAX,MAX-1,...,1,0,0,1,...
  - Each endpoint is held for two cycles.
  - Period = 2^(N+1) cycles (512 for N=8).
- Carrier transitions:
  - dir_up & cnt==MAX: dir_up<=0, cnt holds.
  - !dir_up & cnt==0: dir_up<=1, cnt holds.
  - Otherwise cnt increments when dir_up, decrements when not.
- Duty latching:
  - duty_q<=duty only on the cycle where !dir_up & cnt==0 (period boundary). No mid-period glitches.
  - The first period after reset runs with duty_q=0, so output stays low.
  - Changes to duty take effect from the next period.
- Output: pwm_out <= (cnt < duty_q), unsigned compare, one cycle latency from the carrier.
- Duty boundaries:
  - duty=0: pwm_out constantly 0.
  - duty=MAX: high 2*MAX cycles, low exactly 2 cycles per period (at the carrier peak).
  - 100% is not reachable by design.
- High time: a single contiguous run of 2*duty cycles, centered on the valley. It straddles the period boundary.

Optional Feature:
- Macro: TRIANGULAR_PWM_SYNC_EN.
- Defined:
  - Adds output port period_sync (1 bit, reset 0).
  - Registered; pulses high for exactly one cycle, one cycle after each duty-latch event (aligned with pwm_out latency).
  - Marks the valley / start of period for ADC triggering.
- Undefined: the port and its logic are absent. pwm_out behaviour is identical in both builds.

Decomposition:
- Package triangular_pwm_pkg:
  - default DUTY_WIDTH constant.
  - direction enum typedef (DIR_UP, DIR_DOWN).
- Natural sub-module: tri_carrier. It holds cnt, dir_up and produces a period_boundary strobe.
- Top: duty latch, comparator, output register.

Test Plan:
- Reset: hold rst=1 for 5 cycles with duty=0 -> pwm_out=0, cnt=0. Assert rst asynchronously mid-period -> pwm_out drops to 0 without waiting for a clock edge.
- duty=0 for 3000 cycles after reset -> pwm_out never asserts.
- duty=64 applied after reset:
  - first period stays low (duty_q=0).
  - each following 512-cycle period -> exactly 128 contiguous high cycles.
  - pulse midpoint on the carrier valley.
- Sweep duty 8,16,32,128,192, each for 3000 cycles -> steady-state high counts 16,32,64,256,384 per 512-cycle period.
- duty=255 -> per period 510 high, 2 low, low aligned to the carrier peak (cnt==255 twice).
- duty changed mid-period (64 -> 192 while cnt≈100 counting up) -> current period keeps 128 high cycles; next period has 384. With TRIANGULAR_PWM_SYNC_EN, period_sync pulses once per 512 cycles.
